// File: rtl/day_20_pkg.sv
// Shared types and helpers for the day_20 show-ahead FIFO.
// Operation encoding and pointer wrap function used by top and pointer sub-module.
package day_20_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_t;

  // Increment with explicit wrap at depth-1, so non power-of-2 depths work.
  function automatic int wrap_inc(input int ptr, input int depth);
    if (ptr >= depth - 32'sd1) begin
      return 32'sd0;
    end else begin
      return ptr + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/day_20_ptr.sv
// Wrapping pointer register for the day_20 FIFO; also exposes its next value
// so the top can precompute the registered show-ahead head.
module day_20_ptr
  import day_20_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic [PTR_W-1:0] ptr_nxt_o
);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_nxt_s;

  // Next pointer value
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (en_i) begin
      ptr_nxt_s = PTR_W'(wrap_inc(int'(ptr_r), DEPTH));
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign ptr_o     = ptr_r;
  assign ptr_nxt_o = ptr_nxt_s;

endmodule

// File: rtl/day_20.sv
// day_20: parametrised synchronous show-ahead FIFO with count and almost flags.
// Optional sticky overflow/underflow reporting is built when FIFO_ERR_EN is defined.
module day_20
  import day_20_pkg::*;
#(
  parameter int DEPTH     = 5,
  parameter int DATA_W    = 8,
  parameter int AF_THRESH = 4,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
`ifdef FIFO_ERR_EN
  output logic                       overflow_o,
  output logic                       underflow_o,
  input  logic                       err_clr_i,
`endif
  output logic                       almost_empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_s;
  logic [PTR_W-1:0]  rd_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_s;
  logic [PTR_W-1:0]  wr_nxt_s;

  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              af_r;
  logic              ae_r;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] head_nxt_s;

  logic              pop_ok_s;
  logic              push_ok_s;
  fifo_op_t          op_s;

  assign pop_ok_s  = pop_i & ~empty_r;
  assign push_ok_s = push_i & (~full_r | pop_ok_s);
  assign op_s      = fifo_op_t'({pop_ok_s, push_ok_s});

  day_20_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (pop_ok_s),
    .ptr_o     (rd_ptr_s),
    .ptr_nxt_o (rd_nxt_s)
  );

  day_20_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (push_ok_s),
    .ptr_o     (wr_ptr_s),
    .ptr_nxt_o (wr_nxt_s)
  );

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_s] <= push_data_i;
    end
  end

  // Next occupancy from the accepted operation
  always_comb begin
    count_nxt_s = count_r;
    case (op_s)
      OP_IDLE: count_nxt_s = count_r;
      OP_PUSH: count_nxt_s = count_r + CNT_W'(1);
      OP_POP:  count_nxt_s = count_r - CNT_W'(1);
      OP_BOTH: count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Next head: a word written this cycle into the new head slot bypasses memory
  always_comb begin
    head_nxt_s = '0;
    if (count_nxt_s == CNT_W'(0)) begin
      head_nxt_s = '0;
    end else if (push_ok_s && (wr_ptr_s == rd_nxt_s)) begin
      head_nxt_s = push_data_i;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Count, status flags and head are all registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      head_r  <= '0;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == CNT_W'(0));
      af_r    <= (count_nxt_s >= CNT_W'(AF_THRESH));
      ae_r    <= (count_nxt_s <= CNT_W'(AE_THRESH));
      head_r  <= head_nxt_s;
    end
  end

`ifdef FIFO_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= (push_i & ~push_ok_s) | (overflow_r & ~err_clr_i);
      underflow_r <= (pop_i & ~pop_ok_s) | (underflow_r & ~err_clr_i);
    end
  end

  assign overflow_o  = overflow_r;
  assign underflow_o = underflow_r;
`endif

  assign pop_data_o     = head_r;
  assign count_o        = count_r;
  assign full_o         = full_r;
  assign empty_o        = empty_r;
  assign almost_full_o  = af_r;
  assign almost_empty_o = ae_r;

endmodule

// File: tb/tb_day_20.sv
// Directed testbench for day_20 (DEPTH=5, DATA_W=8, AF=4, AE=1).
// Error-flag checks are included when FIFO_ERR_EN is defined.
module tb_day_20;

  logic       clk;
  logic       reset_n;
  logic       push_i;
  logic [7:0] push_data_i;
  logic       pop_i;
  logic [7:0] pop_data_o;
  logic [2:0] count_o;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic       almost_empty_o;
`ifdef FIFO_ERR_EN
  logic       overflow_o;
  logic       underflow_o;
  logic       err_clr_i;
`endif

  int total;
  int passed;

  day_20 #(.DEPTH(5), .DATA_W(8), .AF_THRESH(4), .AE_THRESH(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .push_i         (push_i),
    .push_data_i    (push_data_i),
    .pop_i          (pop_i),
    .pop_data_o     (pop_data_o),
    .count_o        (count_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
`ifdef FIFO_ERR_EN
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .err_clr_i      (err_clr_i),
`endif
    .almost_empty_o (almost_empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs are then changed away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_i = 1'b0;
    pop_i  = 1'b0;
`ifdef FIFO_ERR_EN
    err_clr_i = 1'b0;
`endif
  endtask

  task automatic test_reset();
    idle();
    push_data_i = 8'h00;
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    step();
    step();
    total++; if (empty_o !== 1'b1) $display("FAIL reset_empty got %b want 1", empty_o); else passed++;
    total++; if (full_o !== 1'b0) $display("FAIL reset_full got %b want 0", full_o); else passed++;
    total++; if (count_o !== 3'd0) $display("FAIL reset_count got %0d want 0", count_o); else passed++;
    total++; if (almost_empty_o !== 1'b1) $display("FAIL reset_ae got %b want 1", almost_empty_o); else passed++;
    total++; if (almost_full_o !== 1'b0) $display("FAIL reset_af got %b want 0", almost_full_o); else passed++;
    total++; if (pop_data_o !== 8'h00) $display("FAIL reset_data got %h want 00", pop_data_o); else passed++;
`ifdef FIFO_ERR_EN
    total++; if ({overflow_o, underflow_o} !== 2'b00) $display("FAIL reset_err got %b want 00", {overflow_o, underflow_o}); else passed++;
`endif
  endtask

  task automatic test_fill();
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 17);
      push_i = 1'b1;
      push_data_i = d;
      step();
      push_i = 1'b0;
      total++; if (count_o !== 3'(i)) $display("FAIL fill_count got %0d want %0d", count_o, i); else passed++;
      total++; if (almost_full_o !== (i >= 4)) $display("FAIL fill_af got %b at count %0d", almost_full_o, i); else passed++;
      total++; if (full_o !== (i == 5)) $display("FAIL fill_full got %b at count %0d", full_o, i); else passed++;
      total++; if (almost_empty_o !== (i <= 1)) $display("FAIL fill_ae got %b at count %0d", almost_empty_o, i); else passed++;
      total++; if (pop_data_o !== 8'h11) $display("FAIL fill_head got %h want 11", pop_data_o); else passed++;
    end
    push_i = 1'b1;
    push_data_i = 8'h66;
    step();
    push_i = 1'b0;
    total++; if (count_o !== 3'd5) $display("FAIL ovf_count got %0d want 5", count_o); else passed++;
    total++; if (pop_data_o !== 8'h11) $display("FAIL ovf_head got %h want 11", pop_data_o); else passed++;
`ifdef FIFO_ERR_EN
    total++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow_o); else passed++;
    total++; if (underflow_o !== 1'b0) $display("FAIL ovf_udf got %b want 0", underflow_o); else passed++;
`endif
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 5; i++) begin
      total++; if (pop_data_o !== 8'(i * 17)) $display("FAIL drain_data got %h want %h", pop_data_o, 8'(i * 17)); else passed++;
      pop_i = 1'b1;
      step();
      pop_i = 1'b0;
      total++; if (count_o !== 3'(5 - i)) $display("FAIL drain_count got %0d want %0d", count_o, 5 - i); else passed++;
    end
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    total++; if (count_o !== 3'd0) $display("FAIL udf_count got %0d want 0", count_o); else passed++;
    total++; if (empty_o !== 1'b1) $display("FAIL udf_empty got %b want 1", empty_o); else passed++;
    total++; if (pop_data_o !== 8'h00) $display("FAIL udf_data got %h want 00", pop_data_o); else passed++;
`ifdef FIFO_ERR_EN
    total++; if (underflow_o !== 1'b1) $display("FAIL udf_flag got %b want 1", underflow_o); else passed++;
    total++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow_o); else passed++;
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    total++; if ({overflow_o, underflow_o} !== 2'b00) $display("FAIL err_clr got %b want 00", {overflow_o, underflow_o}); else passed++;
`endif
  endtask

  task automatic test_full_both();
    logic [7:0] exp_q [$];
    for (int i = 1; i <= 5; i++) begin
      push_i = 1'b1;
      push_data_i = 8'(i);
      step();
    end
    push_i = 1'b0;
    total++; if (full_o !== 1'b1) $display("FAIL both_prefull got %b want 1", full_o); else passed++;
    total++; if (pop_data_o !== 8'h01) $display("FAIL both_head got %h want 01", pop_data_o); else passed++;
    push_i = 1'b1;
    pop_i = 1'b1;
    push_data_i = 8'hA0;
    step();
    idle();
    total++; if (count_o !== 3'd5) $display("FAIL both_count got %0d want 5", count_o); else passed++;
    total++; if (full_o !== 1'b1) $display("FAIL both_full got %b want 1", full_o); else passed++;
`ifdef FIFO_ERR_EN
    total++; if (overflow_o !== 1'b0) $display("FAIL both_ovf got %b want 0", overflow_o); else passed++;
`endif
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'hA0};
    foreach (exp_q[k]) begin
      total++; if (pop_data_o !== exp_q[k]) $display("FAIL both_order got %h want %h", pop_data_o, exp_q[k]); else passed++;
      pop_i = 1'b1;
      step();
      pop_i = 1'b0;
    end
    total++; if (empty_o !== 1'b1) $display("FAIL both_empty got %b want 1", empty_o); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] d;
    q = {};
    for (int i = 0; i < 2; i++) begin
      d = 8'h30 + 8'(i);
      push_i = 1'b1;
      push_data_i = d;
      q.push_back(d);
      step();
    end
    push_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++; if (pop_data_o !== q[0]) $display("FAIL wrap_data got %h want %h iter %0d", pop_data_o, q[0], i); else passed++;
      d = 8'h40 + 8'(i);
      push_i = 1'b1;
      pop_i = 1'b1;
      push_data_i = d;
      step();
      void'(q.pop_front());
      q.push_back(d);
      total++; if (count_o !== 3'd2) $display("FAIL wrap_count got %0d want 2 iter %0d", count_o, i); else passed++;
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      total++; if (pop_data_o !== q[0]) $display("FAIL wrap_tail got %h want %h", pop_data_o, q[0]); else passed++;
      pop_i = 1'b1;
      step();
      pop_i = 1'b0;
      void'(q.pop_front());
    end
    total++; if (empty_o !== 1'b1) $display("FAIL wrap_empty got %b want 1", empty_o); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      push_i = 1'b1;
      push_data_i = 8'hB0 + 8'(i);
      step();
    end
    push_i = 1'b0;
    total++; if (count_o !== 3'd3) $display("FAIL arst_pre got %0d want 3", count_o); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (count_o !== 3'd0) $display("FAIL arst_count got %0d want 0", count_o); else passed++;
    total++; if (empty_o !== 1'b1) $display("FAIL arst_empty got %b want 1", empty_o); else passed++;
    total++; if (almost_empty_o !== 1'b1) $display("FAIL arst_ae got %b want 1", almost_empty_o); else passed++;
    total++; if (pop_data_o !== 8'h00) $display("FAIL arst_data got %h want 00", pop_data_o); else passed++;
    #1;
    reset_n = 1'b1;
    push_i = 1'b1;
    push_data_i = 8'hC3;
    step();
    push_i = 1'b0;
    total++; if (pop_data_o !== 8'hC3) $display("FAIL arst_first got %h want c3", pop_data_o); else passed++;
    total++; if (count_o !== 3'd1) $display("FAIL arst_cnt1 got %0d want 1", count_o); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_fill();
    test_drain();
    test_full_both();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
